// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stage: FSM state encoding and the
// counter wrap point.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

    // Last counter value of a period; a period spans 0..CNT_MAX, i.e. 2^width-1 ticks.
    function automatic int unsigned CNT_MAX(input int unsigned width);
        return (32'd1 << width) - 32'd2;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Prescaler: emits one tick every prescale+1 clocks. The compare is >= so that
// lowering prescale below the running count forces an immediate tick.
module tick_div #(
    parameter int PRE_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [PRE_BITS-1:0] prescale,
    output logic                tick
);

    logic [PRE_BITS-1:0] pre;

    assign tick = (pre >= prescale);

    // NOTE: sequential state is always written with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_BITS'(1);
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// PWM output stage with a valid/ready duty shadow register, period-aligned
// duty updates, programmable prescaler and an enable that drains the period.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRE_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PRE_BITS-1:0] prescale,
    input  logic [WIDTH-1:0]    duty_in,
    input  logic                duty_valid,
    output logic                duty_ready,
    output logic                pwm,
    output logic                period_start,
    output logic [WIDTH-1:0]    duty_q
);

    localparam logic [WIDTH-1:0] CNT_TOP = WIDTH'(CNT_MAX(WIDTH));

    pwm_state_t       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow;
    logic             pending;

    logic             tick;
    logic             boundary;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] duty_nxt;
    logic             pwm_live;

    // Prescaler is held at zero whenever the stage is idle, so a run always
    // starts on a fresh tick phase.
    tick_div #(
        .PRE_BITS(PRE_BITS)
    ) u_tick_div (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == IDLE),
        .prescale (prescale),
        .tick     (tick)
    );

    assign duty_ready = !pending && !rst;
    assign xfer       = duty_valid && duty_ready;
    assign boundary   = (state != IDLE) && tick && (cnt == CNT_TOP);
    assign load       = boundary || ((state == IDLE) && en);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cnt_nxt  = cnt;
        duty_nxt = duty_q;
        if (state == IDLE) begin
            cnt_nxt = '0;
        end else if (tick) begin
            cnt_nxt = (cnt == CNT_TOP) ? '0 : cnt + WIDTH'(1);
        end
        if (load && pending) begin
            duty_nxt = shadow;
        end
    end

    // pwm is registered from next-state values so it always agrees with cnt and duty_q.
    assign pwm_live = (cnt_nxt < duty_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            duty_q       <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            duty_q <= duty_nxt;

            // A transfer in a load cycle lands in the shadow only and stays pending.
            if (xfer) begin
                shadow  <= duty_in;
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state        <= RUN;
                        period_start <= 1'b1;
                        pwm          <= pwm_live;
                    end else begin
                        period_start <= 1'b0;
                        pwm          <= 1'b0;
                    end
                end
                RUN: begin
                    state        <= en ? RUN : DRAIN;
                    period_start <= boundary;
                    pwm          <= pwm_live;
                end
                DRAIN: begin
                    if (en) begin
                        state        <= RUN;
                        period_start <= boundary;
                        pwm          <= pwm_live;
                    end else if (boundary) begin
                        state        <= IDLE;
                        period_start <= 1'b0;
                        pwm          <= 1'b0;
                    end else begin
                        period_start <= 1'b0;
                        pwm          <= pwm_live;
                    end
                end
                default: begin
                    state        <= IDLE;
                    period_start <= 1'b0;
                    pwm          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed testbench for pwm_gen (WIDTH=8, PRE_BITS=8) with hand-computed
// expected waveforms; outputs are sampled 1 ns after each rising edge.
module tb_pwm_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] prescale;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm;
    logic       period_start;
    logic [7:0] duty_q;

    int vectors;
    int miscompares;

    pwm_gen #(
        .WIDTH    (8),
        .PRE_BITS (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .prescale     (prescale),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm          (pwm),
        .period_start (period_start),
        .duty_q       (duty_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_duty(input logic [7:0] v);
        int n;
        n = 0;
        duty_in    = v;
        duty_valid = 1'b1;
        while (!duty_ready && n < 1000) begin
            step(1);
            n++;
        end
        vectors++;
        if (duty_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL push_ready: duty_ready=%b expected 1 within 1000 cycles", duty_ready);
        end
        step(1);
        duty_valid = 1'b0;
        duty_in    = 8'hA5;
    endtask

    task automatic wait_period_start(input int budget);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!period_start && n < budget);
        vectors++;
        if (period_start !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_period_start: period_start=%b expected 1 within %0d cycles", period_start, budget);
        end
    endtask

    // Called on a period_start cycle; runs to the next period_start.
    task automatic measure_period(output int len, output int highs, output int rises);
        logic prev;
        len   = 0;
        highs = 0;
        rises = 0;
        prev  = pwm;
        do begin
            if (pwm === 1'b1) highs++;
            if (len > 0 && pwm === 1'b1 && prev === 1'b0) rises++;
            prev = pwm;
            step(1);
            len++;
        end while (period_start !== 1'b1 && len < 5000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        vectors++;
        if (duty_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low: duty_ready=%b expected 0", duty_ready);
        end
        rst = 1'b0;
        step(1);
        vectors++;
        if (duty_ready !== 1'b1 || pwm !== 1'b0 || period_start !== 1'b0 || duty_q !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_values: ready=%b pwm=%b ps=%b duty_q=%0d expected 1 0 0 0",
                     duty_ready, pwm, period_start, duty_q);
        end
    endtask

    task automatic test_basic();
        int len, highs, rises;
        push_duty(8'd64);
        en = 1'b1;
        step(1);
        vectors++;
        if (period_start !== 1'b1 || duty_q !== 8'd64 || pwm !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_latency: ps=%b duty_q=%0d pwm=%b expected 1 64 1", period_start, duty_q, pwm);
        end
        measure_period(len, highs, rises);
        vectors++;
        if (len != 255 || highs != 64 || rises != 0) begin
            miscompares++;
            $display("FAIL duty64_period: len=%0d highs=%0d rises=%0d expected 255 64 0", len, highs, rises);
        end
        measure_period(len, highs, rises);
        vectors++;
        if (len != 255 || highs != 64) begin
            miscompares++;
            $display("FAIL duty64_repeat: len=%0d highs=%0d expected 255 64", len, highs);
        end
    endtask

    task automatic test_extremes();
        int len, highs, rises;
        push_duty(8'd0);
        wait_period_start(300);
        vectors++;
        if (duty_q !== 8'd0) begin
            miscompares++;
            $display("FAIL duty0_load: duty_q=%0d expected 0", duty_q);
        end
        for (int p = 0; p < 2; p++) begin
            measure_period(len, highs, rises);
            vectors++;
            if (len != 255 || highs != 0) begin
                miscompares++;
                $display("FAIL duty0_period%0d: len=%0d highs=%0d expected 255 0", p, len, highs);
            end
        end
        push_duty(8'd255);
        wait_period_start(300);
        vectors++;
        if (duty_q !== 8'd255) begin
            miscompares++;
            $display("FAIL duty255_load: duty_q=%0d expected 255", duty_q);
        end
        for (int p = 0; p < 2; p++) begin
            measure_period(len, highs, rises);
            vectors++;
            if (len != 255 || highs != 255) begin
                miscompares++;
                $display("FAIL duty255_period%0d: len=%0d highs=%0d expected 255 255", p, len, highs);
            end
        end
    endtask

    task automatic test_prescale();
        int len, highs, rises, n;
        push_duty(8'd128);
        wait_period_start(300);
        prescale = 8'd3;
        measure_period(len, highs, rises);
        vectors++;
        if (len != 1020 || highs != 512 || rises != 0) begin
            miscompares++;
            $display("FAIL prescale3_period: len=%0d highs=%0d rises=%0d expected 1020 512 0", len, highs, rises);
        end
        push_duty(8'd1);
        wait_period_start(2000);
        step(2);
        vectors++;
        if (pwm !== 1'b1) begin
            miscompares++;
            $display("FAIL prescale_hold: pwm=%b expected 1 (cnt 0)", pwm);
        end
        prescale = 8'd0;
        step(1);
        vectors++;
        if (pwm !== 1'b0) begin
            miscompares++;
            $display("FAIL prescale_lower_tick: pwm=%b expected 0 (cnt 1)", pwm);
        end
        n = 3;
        while (period_start !== 1'b1 && n < 2000) begin
            step(1);
            n++;
        end
        vectors++;
        if (n != 257) begin
            miscompares++;
            $display("FAIL prescale_switch_len: len=%0d expected 257", n);
        end
    endtask

    task automatic test_shadow();
        int n, bad;
        push_duty(8'd64);
        wait_period_start(300);
        vectors++;
        if (duty_q !== 8'd64) begin
            miscompares++;
            $display("FAIL shadow_active64: duty_q=%0d expected 64", duty_q);
        end
        step(100);
        duty_in    = 8'd128;
        duty_valid = 1'b1;
        step(1);
        duty_in = 8'd200;
        vectors++;
        if (duty_ready !== 1'b0 || duty_q !== 8'd64) begin
            miscompares++;
            $display("FAIL shadow_accept: ready=%b duty_q=%0d expected 0 64", duty_ready, duty_q);
        end
        n   = 0;
        bad = 0;
        do begin
            step(1);
            n++;
            if (period_start !== 1'b1 && (duty_ready !== 1'b0 || duty_q !== 8'd64)) bad++;
        end while (period_start !== 1'b1 && n < 300);
        vectors++;
        if (bad != 0 || n != 154) begin
            miscompares++;
            $display("FAIL shadow_stall: bad_cycles=%0d wait=%0d expected 0 154", bad, n);
        end
        vectors++;
        if (duty_q !== 8'd128 || duty_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL shadow_boundary: duty_q=%0d ready=%b expected 128 1", duty_q, duty_ready);
        end
        step(1);
        duty_valid = 1'b0;
        vectors++;
        if (duty_ready !== 1'b0 || duty_q !== 8'd128) begin
            miscompares++;
            $display("FAIL back_to_back_accept: ready=%b duty_q=%0d expected 0 128", duty_ready, duty_q);
        end
        wait_period_start(300);
        vectors++;
        if (duty_q !== 8'd200 || duty_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back_load: duty_q=%0d ready=%b expected 200 1", duty_q, duty_ready);
        end
    endtask

    task automatic test_drain();
        int n, bad, len, highs, rises;
        push_duty(8'd255);
        wait_period_start(300);
        step(10);
        en  = 1'b0;
        bad = 0;
        for (int i = 1; i <= 244; i++) begin
            step(1);
            if (pwm !== 1'b1 || period_start !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL drain_continue: bad_cycles=%0d expected 0", bad);
        end
        step(1);
        vectors++;
        if (pwm !== 1'b0 || period_start !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_to_idle: pwm=%b ps=%b expected 0 0", pwm, period_start);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (pwm !== 1'b0 || period_start !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_quiet: bad_cycles=%0d expected 0", bad);
        end
        en = 1'b1;
        step(1);
        vectors++;
        if (period_start !== 1'b1 || pwm !== 1'b1) begin
            miscompares++;
            $display("FAIL rerun_start: ps=%b pwm=%b expected 1 1", period_start, pwm);
        end
        step(20);
        en = 1'b0;
        step(30);
        en = 1'b1;
        n  = 50;
        while (period_start !== 1'b1 && n < 600) begin
            step(1);
            n++;
        end
        vectors++;
        if (n != 255) begin
            miscompares++;
            $display("FAIL drain_reenable_len: len=%0d expected 255", n);
        end
        measure_period(len, highs, rises);
        vectors++;
        if (len != 255 || highs != 255) begin
            miscompares++;
            $display("FAIL reenable_run: len=%0d highs=%0d expected 255 255", len, highs);
        end
    endtask

    task automatic test_reset_mid();
        step(5);
        push_duty(8'd99);
        vectors++;
        if (duty_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_pending: ready=%b expected 0", duty_ready);
        end
        rst = 1'b1;
        step(1);
        vectors++;
        if (pwm !== 1'b0 || period_start !== 1'b0 || duty_q !== 8'd0 || duty_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: pwm=%b ps=%b duty_q=%0d ready=%b expected 0 0 0 0",
                     pwm, period_start, duty_q, duty_ready);
        end
        en  = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if (duty_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_ready: ready=%b expected 1", duty_ready);
        end
        en = 1'b1;
        step(1);
        vectors++;
        if (period_start !== 1'b1 || duty_q !== 8'd0 || pwm !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_discard: ps=%b duty_q=%0d pwm=%b expected 1 0 0",
                     period_start, duty_q, pwm);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        en          = 1'b0;
        prescale    = 8'd0;
        duty_in     = 8'd0;
        duty_valid  = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_prescale();
        test_shadow();
        test_drain();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
